mem_arbiter_2port: RTL and testbench

Two-requester arbiter sharing the single memory port between instruction fetch (port 0) and data access (port 1) in the multicycle TinyRV1 processor. It sits between the processor and the unified memory, accepts val/rdy requests from both sides, and issues at most one memory transaction at a time. It routes each response back to the requester that owns it. It also keeps per-port grant counters, which the simulation harness reports alongside `cycle_count`.

---
 rtl/mem_arbiter_2port.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter_2port.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2port.sv
// Two-port memory arbiter: instruction fetch (port 0) and data access (port 1)
// share one memory port with at most one transaction outstanding at a time.
module mem_arbiter_2port #(
  parameter bit p_fixed_prio = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic        req0_type,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,

  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic        req1_type,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,

  output logic        resp0_val,
  output logic [31:0] resp0_data,
  output logic        resp1_val,
  output logic [31:0] resp1_data,

  output logic        mem_req_val,
  input  logic        mem_req_rdy,
  output logic        mem_req_type,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,

  input  logic        mem_resp_val,
  input  logic [31:0] mem_resp_data,

  output logic [31:0] grant0_count,
  output logic [31:0] grant1_count,

  // {busy, owner, prio}
  output logic [2:0]  dbg_state
);

  // Handshake rule for every val/rdy pair here: a transfer happens on the
  // rising edge where val and rdy are both high; val never depends on rdy,
  // and a requester may drop val before a transfer without side effects.

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q,  prio_d;
  logic [31:0] cnt0_q,  cnt1_q;

  logic        any_val;
  logic        winner;
  logic        accept;

  assign any_val = req0_val | req1_val;

  // Lone requester wins outright; contention resolves by parameter or prio.
  always_comb begin
    winner = 1'b0;
    if (req0_val && !req1_val) begin
      winner = 1'b0;
    end else if (!req0_val && req1_val) begin
      winner = 1'b1;
    end else if (req0_val && req1_val) begin
      winner = p_fixed_prio ? 1'b0 : prio_q;
    end
  end

  assign accept = !rst && (state_q == IDLE) && any_val && mem_req_rdy;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    prio_d        = prio_q;
    req0_rdy      = 1'b0;
    req1_rdy      = 1'b0;
    resp0_val     = 1'b0;
    resp1_val     = 1'b0;
    mem_req_val   = 1'b0;
    mem_req_type  = winner ? req1_type  : req0_type;
    mem_req_addr  = winner ? req1_addr  : req0_addr;
    mem_req_wdata = winner ? req1_wdata : req0_wdata;

    case (state_q)
      IDLE: begin
        mem_req_val = !rst && any_val;
        req0_rdy    = !rst && any_val && !winner && mem_req_rdy;
        req1_rdy    = !rst && any_val &&  winner && mem_req_rdy;
        if (accept) begin
          state_d = BUSY;
          owner_d = winner;
          prio_d  = ~winner;
        end
      end
      BUSY: begin
        if (!rst && mem_resp_val) begin
          resp0_val = !owner_q;
          resp1_val =  owner_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Grant counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 32'd0;
      cnt1_q <= 32'd0;
    end else if (accept) begin
      if (!winner && cnt0_q != CNT_MAX) begin
        cnt0_q <= cnt0_q + 32'd1;
      end
      if (winner && cnt1_q != CNT_MAX) begin
        cnt1_q <= cnt1_q + 32'd1;
      end
    end
  end

  assign resp0_data   = mem_resp_data;
  assign resp1_data   = mem_resp_data;
  assign grant0_count = cnt0_q;
  assign grant1_count = cnt1_q;
  assign dbg_state    = {state_q == BUSY, owner_q, prio_q};

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Self-checking bench for mem_arbiter_2port: table vectors, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter_2port;

  logic        clk;
  logic        rst;
  logic        req0_val, req0_type, req1_val, req1_type;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        mem_req_rdy, mem_resp_val;
  logic [31:0] mem_resp_data;

  // round-robin instance outputs
  logic        d_r0, d_r1, d_s0, d_s1, d_mval, d_mtype;
  logic [31:0] d_sd0, d_sd1, d_maddr, d_mwdata, d_c0, d_c1;
  logic [2:0]  d_dbg;
  // fixed-priority instance outputs
  logic        f_r0, f_r1, f_s0, f_s1, f_mval, f_mtype;
  logic [31:0] f_sd0, f_sd1, f_maddr, f_mwdata, f_c0, f_c1;
  logic [2:0]  f_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter_2port #(.p_fixed_prio(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(d_r0), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_val(req1_val), .req1_rdy(d_r1), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp0_val(d_s0), .resp0_data(d_sd0), .resp1_val(d_s1), .resp1_data(d_sd1),
    .mem_req_val(d_mval), .mem_req_rdy(mem_req_rdy), .mem_req_type(d_mtype),
    .mem_req_addr(d_maddr), .mem_req_wdata(d_mwdata),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .grant0_count(d_c0), .grant1_count(d_c1), .dbg_state(d_dbg)
  );

  mem_arbiter_2port #(.p_fixed_prio(1'b1)) u_fix (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(f_r0), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_val(req1_val), .req1_rdy(f_r1), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp0_val(f_s0), .resp0_data(f_sd0), .resp1_val(f_s1), .resp1_data(f_sd1),
    .mem_req_val(f_mval), .mem_req_rdy(mem_req_rdy), .mem_req_type(f_mtype),
    .mem_req_addr(f_maddr), .mem_req_wdata(f_mwdata),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .grant0_count(f_c0), .grant1_count(f_c1), .dbg_state(f_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_val = 0; req0_type = 0; req0_addr = 0; req0_wdata = 0;
    req1_val = 0; req1_type = 0; req1_addr = 0; req1_wdata = 0;
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- behavioural model (one slot per instance) ----------------
  bit          m_busy [2];
  bit          m_owner[2];
  bit          m_prio [2];
  longint      m_cnt  [2][2];
  logic [31:0] exp_q[$];

  function automatic bit m_fixed(input int k);
    return (k == 1);
  endfunction

  function automatic bit m_winner(input int k);
    if (req0_val && req1_val) return m_fixed(k) ? 1'b0 : m_prio[k];
    return req1_val && !req0_val;
  endfunction

  task automatic m_reset_all();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_prio[k] = 0;
      m_cnt[k][0] = 0; m_cnt[k][1] = 0;
    end
  endtask

  task automatic m_check(input int k, input logic r0, input logic r1, input logic mv,
                         input logic mt, input logic [31:0] ma, input logic [31:0] mw,
                         input logic s0, input logic s1, input logic [31:0] sd0,
                         input logic [31:0] c0, input logic [31:0] c1, input logic [2:0] dbg);
    bit any, w, can_req, resp_now;
    any      = req0_val || req1_val;
    w        = m_winner(k);
    can_req  = !rst && !m_busy[k] && any;
    resp_now = !rst && m_busy[k] && mem_resp_val;
    chk($sformatf("rnd%0d_mem_req_val", k), {31'd0, mv}, {31'd0, can_req});
    chk($sformatf("rnd%0d_req0_rdy", k), {31'd0, r0}, {31'd0, can_req && mem_req_rdy && !w});
    chk($sformatf("rnd%0d_req1_rdy", k), {31'd0, r1}, {31'd0, can_req && mem_req_rdy && w});
    chk($sformatf("rnd%0d_resp0_val", k), {31'd0, s0}, {31'd0, resp_now && !m_owner[k]});
    chk($sformatf("rnd%0d_resp1_val", k), {31'd0, s1}, {31'd0, resp_now && m_owner[k]});
    chk($sformatf("rnd%0d_resp_data", k), sd0, mem_resp_data);
    chk($sformatf("rnd%0d_grant0", k), c0, m_cnt[k][0][31:0]);
    chk($sformatf("rnd%0d_grant1", k), c1, m_cnt[k][1][31:0]);
    chk($sformatf("rnd%0d_busy", k), {31'd0, dbg[2]}, {31'd0, m_busy[k]});
    if (can_req) begin
      chk($sformatf("rnd%0d_mem_req_addr", k), ma, w ? req1_addr : req0_addr);
      chk($sformatf("rnd%0d_mem_req_wdata", k), mw, w ? req1_wdata : req0_wdata);
      chk($sformatf("rnd%0d_mem_req_type", k), {31'd0, mt}, {31'd0, w ? req1_type : req0_type});
    end
  endtask

  task automatic m_step(input int k);
    bit w;
    w = m_winner(k);
    if (rst) begin
      m_busy[k] = 0; m_owner[k] = 0; m_prio[k] = 0;
      m_cnt[k][0] = 0; m_cnt[k][1] = 0;
    end else if (!m_busy[k]) begin
      if ((req0_val || req1_val) && mem_req_rdy) begin
        m_busy[k] = 1; m_owner[k] = w; m_prio[k] = !w;
        if (m_cnt[k][w] < 64'hFFFF_FFFF) m_cnt[k][w]++;
      end
    end else if (mem_resp_val) begin
      m_busy[k] = 0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v0, v1, mrdy, mresp;
    logic        e_r0, e_r1, e_mval, e_s0, e_s1, e_sel;
    logic [31:0] e_c0, e_c1;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int strobes;
    logic [31:0] saved;
    rst = 1'b1;
    idle_inputs();
    m_reset_all();

    // Reset holds outputs quiet even with active inputs.
    req0_val = 1; req1_val = 1; mem_req_rdy = 1; mem_resp_val = 1;
    @(negedge clk);
    chk("rst_req0_rdy", {31'd0, d_r0}, 32'd0);
    chk("rst_req1_rdy", {31'd0, d_r1}, 32'd0);
    chk("rst_mem_req_val", {31'd0, d_mval}, 32'd0);
    chk("rst_resp0_val", {31'd0, d_s0}, 32'd0);
    chk("rst_resp1_val", {31'd0, d_s1}, 32'd0);
    tick();
    @(negedge clk);
    chk("rst_grant0", d_c0, 32'd0);
    chk("rst_grant1", d_c1, 32'd0);
    chk("rst_dbg", {29'd0, d_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();

    // ---- table: round-robin sequence then idle / single-port corners ----
    //           v0 v1 rdy rsp | r0 r1 mv s0 s1 sel | c0 c1
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 32'd0, 32'd0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'd1, 32'd0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'd1, 32'd0};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'd1, 32'd1};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 32'd1, 32'd1};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'd2, 32'd1};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'd2, 32'd1};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'd2, 32'd2};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 32'd2, 32'd2};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'd2, 32'd2};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 32'd2, 32'd2};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'd3, 32'd2};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'd3, 32'd2};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'd3, 32'd2};
    tbl[14] = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'd3, 32'd3};

    for (int i = 0; i < 15; i++) begin
      req0_val = tbl[i].v0; req1_val = tbl[i].v1;
      mem_req_rdy = tbl[i].mrdy; mem_resp_val = tbl[i].mresp;
      req0_addr = 32'h1000 + i; req1_addr = 32'h2000 + i;
      @(negedge clk);
      chk($sformatf("tbl%0d_req0_rdy", i), {31'd0, d_r0}, {31'd0, tbl[i].e_r0});
      chk($sformatf("tbl%0d_req1_rdy", i), {31'd0, d_r1}, {31'd0, tbl[i].e_r1});
      chk($sformatf("tbl%0d_mem_req_val", i), {31'd0, d_mval}, {31'd0, tbl[i].e_mval});
      chk($sformatf("tbl%0d_resp0_val", i), {31'd0, d_s0}, {31'd0, tbl[i].e_s0});
      chk($sformatf("tbl%0d_resp1_val", i), {31'd0, d_s1}, {31'd0, tbl[i].e_s1});
      chk($sformatf("tbl%0d_grant0", i), d_c0, tbl[i].e_c0);
      chk($sformatf("tbl%0d_grant1", i), d_c1, tbl[i].e_c1);
      if (tbl[i].e_mval)
        chk($sformatf("tbl%0d_mem_req_addr", i), d_maddr,
            tbl[i].e_sel ? 32'h2000 + i : 32'h1000 + i);
      tick();
    end

    // ---- single read ----
    do_reset();
    req0_val = 1; req0_type = 0; req0_addr = 32'h0000_0010; mem_req_rdy = 1;
    @(negedge clk);
    chk("rd_req0_rdy", {31'd0, d_r0}, 32'd1);
    chk("rd_mem_req_addr", d_maddr, 32'h0000_0010);
    chk("rd_mem_req_type", {31'd0, d_mtype}, 32'd0);
    tick();
    req0_val = 0; mem_resp_val = 1; mem_resp_data = 32'h1234_5678;
    @(negedge clk);
    chk("rd_resp0_val", {31'd0, d_s0}, 32'd1);
    chk("rd_resp0_data", d_sd0, 32'h1234_5678);
    chk("rd_resp1_val", {31'd0, d_s1}, 32'd0);
    chk("rd_grant0", d_c0, 32'd1);
    tick();

    // ---- fixed priority: both requesters held for 4 transactions ----
    do_reset();
    req0_val = 1; req1_val = 1; mem_req_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      mem_resp_val = (i % 2 == 1);
      @(negedge clk);
      if (i % 2 == 0) begin
        chk($sformatf("fix%0d_req0_rdy", i), {31'd0, f_r0}, 32'd1);
        chk($sformatf("fix%0d_req1_rdy", i), {31'd0, f_r1}, 32'd0);
      end else begin
        chk($sformatf("fix%0d_resp0_val", i), {31'd0, f_s0}, 32'd1);
      end
      tick();
    end
    @(negedge clk);
    chk("fix_grant0", f_c0, 32'd4);
    chk("fix_grant1", f_c1, 32'd0);
    tick();

    // ---- backpressure then two-cycle memory latency ----
    do_reset();
    req1_val = 1; req1_type = 1; req1_addr = 32'h100; req1_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_req1_rdy", i), {31'd0, d_r1}, 32'd0);
      chk($sformatf("bp%0d_mem_req_val", i), {31'd0, d_mval}, 32'd1);
      chk($sformatf("bp%0d_grant1", i), d_c1, 32'd0);
      chk($sformatf("bp%0d_prio", i), {31'd0, d_dbg[0]}, 32'd0);
      tick();
    end
    mem_req_rdy = 1;
    @(negedge clk);
    chk("bp_req1_rdy", {31'd0, d_r1}, 32'd1);
    chk("bp_mem_req_wdata", d_mwdata, 32'hDEAD_BEEF);
    chk("bp_mem_req_addr", d_maddr, 32'h100);
    chk("bp_mem_req_type", {31'd0, d_mtype}, 32'd1);
    tick();
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_val = (i == 1);
      if (i == 2) req1_val = 0;
      @(negedge clk);
      if (d_s1) strobes++;
      if (i < 2) begin
        chk($sformatf("bp_busy%0d_req1_rdy", i), {31'd0, d_r1}, 32'd0);
        chk($sformatf("bp_busy%0d_mem_req_val", i), {31'd0, d_mval}, 32'd0);
      end
      tick();
    end
    mem_resp_val = 0;
    chk("bp_resp1_strobes", strobes, 32'd1);
    chk("bp_grant1", d_c1, 32'd1);

    // ---- reset mid-transaction ----
    do_reset();
    req1_val = 1; mem_req_rdy = 1;
    @(negedge clk);
    chk("mr_req1_rdy", {31'd0, d_r1}, 32'd1);
    tick();
    req1_val = 0; rst = 1;
    tick();
    rst = 0; mem_resp_val = 1;
    @(negedge clk);
    chk("mr_resp1_val", {31'd0, d_s1}, 32'd0);
    chk("mr_resp0_val", {31'd0, d_s0}, 32'd0);
    chk("mr_grant1", d_c1, 32'd0);
    chk("mr_grant0", d_c0, 32'd0);
    tick();
    mem_resp_val = 0; req0_val = 1; req1_val = 1;
    @(negedge clk);
    chk("mr_next_req0_rdy", {31'd0, d_r0}, 32'd1);
    chk("mr_next_req1_rdy", {31'd0, d_r1}, 32'd0);
    tick();

    // ---- spurious response while idle ----
    do_reset();
    mem_resp_val = 1; mem_req_rdy = 1;
    @(negedge clk);
    chk("sp_resp0_val", {31'd0, d_s0}, 32'd0);
    chk("sp_resp1_val", {31'd0, d_s1}, 32'd0);
    tick();
    mem_resp_val = 0;
    @(negedge clk);
    chk("sp_dbg", {29'd0, d_dbg}, 32'd0);
    chk("sp_grant0", d_c0, 32'd0);
    tick();

    // ---- saturating grant counter ----
    force dut.cnt0_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt0_q;
    @(negedge clk);
    saved = d_c0;
    chk("sat_preload", saved, 32'hFFFF_FFFE);
    tick();
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF);
    for (int g = 0; g < 2; g++) begin
      req0_val = 1; mem_resp_val = 0;
      tick();
      req0_val = 0; mem_resp_val = 1;
      tick();
      mem_resp_val = 0;
      @(negedge clk);
      if (g == 1) chk("sat_after_grants", d_c0, exp_q.pop_front());
      else        chk("sat_first_grant", d_c0, exp_q.pop_front());
      tick();
    end

    // ---- randomized traffic against the model, both instances ----
    do_reset();
    m_reset_all();
    for (int c = 0; c < 1500; c++) begin
      rst          = ($urandom_range(0, 79) == 0);
      req0_val     = ($urandom_range(0, 2) != 0);
      req1_val     = ($urandom_range(0, 2) != 0);
      req0_type    = $urandom_range(0, 1);
      req1_type    = $urandom_range(0, 1);
      req0_addr    = $urandom; req0_wdata = $urandom;
      req1_addr    = $urandom; req1_wdata = $urandom;
      mem_req_rdy  = ($urandom_range(0, 3) != 0);
      mem_resp_val = ($urandom_range(0, 2) == 0);
      mem_resp_data = $urandom;
      @(negedge clk);
      m_check(0, d_r0, d_r1, d_mval, d_mtype, d_maddr, d_mwdata, d_s0, d_s1, d_sd0, d_c0, d_c1, d_dbg);
      m_check(1, f_r0, f_r1, f_mval, f_mtype, f_maddr, f_mwdata, f_s0, f_s1, f_sd1, f_c0, f_c1, f_dbg);
      m_step(0);
      m_step(1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
